// File: rtl/cpu_control_pkg.sv
// Shared encodings for the accumulator-machine control unit: opcodes, ALU ops,
// PC source selects, FSM states and the per-state control word.
package cpu_control_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JN    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_IR   = 2'b01;
  localparam logic [1:0] PC_SRC_ZERO = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F_ADDR = 4'd1,
    ST_F_MEM  = 4'd2,
    ST_F_IR   = 4'd3,
    ST_DECODE = 4'd4,
    ST_E_ADDR = 4'd5,
    ST_E_MEM  = 4'd6,
    ST_E_MBR  = 4'd7,
    ST_E_ACC  = 4'd8,
    ST_S_WR   = 4'd9,
    ST_JMP    = 4'd10,
    ST_HALT   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_NEXT  = 3'd0,
    CLS_ACC   = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JUMP  = 3'd3,
    CLS_HALT  = 3'd4
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mar_write;
    logic       mar_src;
    logic       mbr_write;
    logic       mbr_src;
    logic       ir_write;
    logic       acc_write;
    logic       acc_src;
    logic [3:0] alu_op;
    logic       mem_we;
    logic       halted;
  } ctrl_t;

  // IDLE and HALT keep PC parked at zero so a start launches fetch from address 0.
  function automatic ctrl_t ctrl_for(input state_t st, input logic is_store,
                                     input logic acc_src, input logic [3:0] alu_op);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IDLE:   begin c.pc_write = 1'b1; c.pc_src = PC_SRC_ZERO; end
      ST_F_ADDR: c.mar_write = 1'b1;
      ST_F_IR:   begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.pc_src = PC_SRC_INC; end
      ST_E_ADDR: begin
        c.mar_write = 1'b1;
        c.mar_src   = 1'b1;
        c.mbr_write = is_store;
        c.mbr_src   = is_store;
      end
      ST_E_MBR:  c.mbr_write = 1'b1;
      ST_E_ACC:  begin c.acc_write = 1'b1; c.acc_src = acc_src; c.alu_op = alu_op; end
      ST_S_WR:   c.mem_we = 1'b1;
      ST_JMP:    begin c.pc_write = 1'b1; c.pc_src = PC_SRC_IR; end
      ST_HALT:   begin c.halted = 1'b1; c.pc_write = 1'b1; c.pc_src = PC_SRC_ZERO; end
      ST_F_MEM, ST_DECODE, ST_E_MEM: c = '0;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Opcode classifier: maps opcode and ACC flags to the execute path, ALU op,
// ACC source and illegal-opcode flag.
module cpu_control_decode
  import cpu_control_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  output op_class_t  op_class,
  output logic [3:0] alu_op,
  output logic       acc_src,
  output logic       illegal
);

  // Classify the opcode; conditional branches resolve here from the ACC flags.
  always_comb begin
    op_class = CLS_NEXT;
    alu_op   = ALU_ADD;
    acc_src  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP:   op_class = CLS_NEXT;
      OP_LOAD:  begin op_class = CLS_ACC; acc_src = 1'b1; end
      OP_STORE: op_class = CLS_STORE;
      OP_ADD:   begin op_class = CLS_ACC; alu_op = ALU_ADD; end
      OP_SUB:   begin op_class = CLS_ACC; alu_op = ALU_SUB; end
      OP_AND:   begin op_class = CLS_ACC; alu_op = ALU_AND; end
      OP_OR:    begin op_class = CLS_ACC; alu_op = ALU_OR; end
      OP_JUMP:  op_class = CLS_JUMP;
      OP_JZ:    op_class = acc_zero ? CLS_JUMP : CLS_NEXT;
      OP_JN:    op_class = acc_neg ? CLS_JUMP : CLS_NEXT;
      OP_HALT:  op_class = CLS_HALT;
      default:  begin op_class = CLS_HALT; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
// Control outputs are registered from the next state, so they track the state register.
module cpu_control_fsm
  import cpu_control_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      ir_in,
  input  logic             acc_zero,
  input  logic             acc_neg,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mar_write,
  output logic             mar_src,
  output logic             mbr_write,
  output logic             mbr_src,
  output logic             ir_write,
  output logic             acc_write,
  output logic             acc_src,
  output logic [3:0]       alu_op,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_r;
  state_t           next_state_s;
  ctrl_t            ctrl_r;
  logic             illegal_r;
  logic [CNT_W-1:0] count_r;
  op_class_t        dec_class_s;
  logic [3:0]       dec_alu_op_s;
  logic             dec_acc_src_s;
  logic             dec_illegal_s;
  logic             retire_s;
  logic             unused_s;

  // The operand field is routed to PC/MAR by the datapath, not by this block.
  assign unused_s = ^{ir_in[11:0], (ADDR_W >= 12)};

  cpu_control_decode u_decode (
    .opcode   (ir_in[15:12]),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg),
    .op_class (dec_class_s),
    .alu_op   (dec_alu_op_s),
    .acc_src  (dec_acc_src_s),
    .illegal  (dec_illegal_s)
  );

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = start ? ST_F_ADDR : ST_IDLE;
      ST_F_ADDR: next_state_s = ST_F_MEM;
      ST_F_MEM:  next_state_s = ST_F_IR;
      ST_F_IR:   next_state_s = ST_DECODE;
      ST_DECODE: begin
        case (dec_class_s)
          CLS_NEXT:  next_state_s = ST_F_ADDR;
          CLS_ACC:   next_state_s = ST_E_ADDR;
          CLS_STORE: next_state_s = ST_E_ADDR;
          CLS_JUMP:  next_state_s = ST_JMP;
          CLS_HALT:  next_state_s = ST_HALT;
          default:   next_state_s = ST_HALT;
        endcase
      end
      ST_E_ADDR: next_state_s = (dec_class_s == CLS_STORE) ? ST_S_WR : ST_E_MEM;
      ST_E_MEM:  next_state_s = ST_E_MBR;
      ST_E_MBR:  next_state_s = ST_E_ACC;
      ST_E_ACC:  next_state_s = ST_F_ADDR;
      ST_S_WR:   next_state_s = ST_F_ADDR;
      ST_JMP:    next_state_s = ST_F_ADDR;
      ST_HALT:   next_state_s = start ? ST_F_ADDR : ST_HALT;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Last cycle of an instruction; illegal opcodes never retire.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      ST_E_ACC, ST_S_WR, ST_JMP: retire_s = 1'b1;
      ST_DECODE: retire_s = (dec_class_s == CLS_NEXT) ||
                            ((dec_class_s == CLS_HALT) && !dec_illegal_s);
      default:   retire_s = 1'b0;
    endcase
  end

  // State, registered control word, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ctrl_r    <= '0;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_for(next_state_s, dec_class_s == CLS_STORE, dec_acc_src_s, dec_alu_op_s);
      if ((state_r == ST_DECODE) && dec_illegal_s) begin
        illegal_r <= 1'b1;
      end else if ((state_r == ST_HALT) && start) begin
        illegal_r <= 1'b0;
      end else begin
        illegal_r <= illegal_r;
      end
      if (retire_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign pc_write    = ctrl_r.pc_write;
  assign pc_src      = ctrl_r.pc_src;
  assign mar_write   = ctrl_r.mar_write;
  assign mar_src     = ctrl_r.mar_src;
  assign mbr_write   = ctrl_r.mbr_write;
  assign mbr_src     = ctrl_r.mbr_src;
  assign ir_write    = ctrl_r.ir_write;
  assign acc_write   = ctrl_r.acc_write;
  assign acc_src     = ctrl_r.acc_src;
  assign alu_op      = ctrl_r.alu_op;
  assign mem_we      = ctrl_r.mem_we;
  assign halted      = ctrl_r.halted;
  assign illegal     = illegal_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: an instruction-level model queues the expected control word
// for every cycle; a negedge monitor pops and compares.
module tb_cpu_control_fsm;

  localparam int ADDR_W = 14;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset, start, acc_zero, acc_neg;
  logic [15:0]      ir_in;
  logic             pc_write, mar_write, mar_src, mbr_write, mbr_src;
  logic             ir_write, acc_write, acc_src, mem_we, halted, illegal;
  logic [1:0]       pc_src;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] instr_count;

  cpu_control_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .ir_in(ir_in),
    .acc_zero(acc_zero), .acc_neg(acc_neg),
    .pc_write(pc_write), .pc_src(pc_src), .mar_write(mar_write), .mar_src(mar_src),
    .mbr_write(mbr_write), .mbr_src(mbr_src), .ir_write(ir_write),
    .acc_write(acc_write), .acc_src(acc_src), .alu_op(alu_op), .mem_we(mem_we),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             mar_write;
    logic             mar_src;
    logic             mbr_write;
    logic             mbr_src;
    logic             ir_write;
    logic             acc_write;
    logic             acc_src;
    logic [3:0]       alu_op;
    logic             mem_we;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  localparam int K_FA = 0, K_FM = 1, K_FI = 2, K_DEC = 3, K_EA = 4, K_EM = 5;
  localparam int K_EB = 6, K_EC = 7, K_SW = 8, K_JP = 9, K_IDLE = 10, K_HALT = 11, K_RST = 12;

  exp_t             exp_q[$];
  int               vectors, miscompares;
  logic [CNT_W-1:0] cnt_m;
  logic             ill_m;
  int               park_m;  // 0 running, 1 idle, 2 halted
  exp_t             cur_e;
  obs_t             act_o;

  function automatic logic [3:0] alu_map(input logic [3:0] op);
    case (op)
      4'h4:    return 4'b0001;
      4'h5:    return 4'b1000;
      4'h6:    return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Control word the datapath should see during one step of an instruction.
  function automatic obs_t step_word(input int k, input logic [3:0] op);
    obs_t o;
    o = '0;
    case (k)
      K_FA:   o.mar_write = 1'b1;
      K_FI:   begin o.ir_write = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'b00; end
      K_EA:   begin
        o.mar_write = 1'b1; o.mar_src = 1'b1;
        o.mbr_write = (op == 4'h2); o.mbr_src = (op == 4'h2);
      end
      K_EB:   o.mbr_write = 1'b1;
      K_EC:   begin o.acc_write = 1'b1; o.acc_src = (op == 4'h1); o.alu_op = alu_map(op); end
      K_SW:   o.mem_we = 1'b1;
      K_JP:   begin o.pc_write = 1'b1; o.pc_src = 2'b01; end
      K_IDLE: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      K_HALT: begin o.pc_write = 1'b1; o.pc_src = 2'b10; o.halted = 1'b1; end
      default: o = '0;
    endcase
    o.illegal = ill_m;
    o.cnt     = cnt_m;
    if (k == K_RST) o = '0;
    return o;
  endfunction

  task automatic push(input int k, input logic [3:0] op, input string tag);
    exp_t e;
    e.v   = step_word(k, op);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; asserts reset mid-cycle and expects everything cleared at once.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    cnt_m = '0;
    ill_m = 1'b0;
    push(K_RST, 4'h0, "reset");
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 park_m = 1;
  endtask

  // m cycles in IDLE/HALT; with go, start is raised on the last one.
  task automatic park(input int m, input bit go);
    for (int i = 0; i < m; i++) begin
      start = (go && (i == m - 1)) ? 1'b1 : 1'b0;
      push((park_m == 2) ? K_HALT : K_IDLE, 4'h0, (park_m == 2) ? "halt_park" : "idle_park");
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (go) begin
      ill_m  = 1'b0;
      park_m = 0;
    end
  endtask

  // Called at posedge+1 in F_ADDR. abort_at >= 0 resets during that step.
  task automatic run_instr(input logic [15:0] ir, input logic z, input logic n, input int abort_at);
    int         steps[$];
    logic [3:0] op;
    int         limit;
    op       = ir[15:12];
    ir_in    = ir;
    acc_zero = z;
    acc_neg  = n;
    start    = 1'($urandom_range(0, 1));
    steps    = '{K_FA, K_FM, K_FI, K_DEC};
    if (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6}) begin
      steps.push_back(K_EA); steps.push_back(K_EM); steps.push_back(K_EB); steps.push_back(K_EC);
    end else if (op == 4'h2) begin
      steps.push_back(K_EA); steps.push_back(K_SW);
    end else if ((op == 4'h7) || ((op == 4'h8) && z) || ((op == 4'h9) && n)) begin
      steps.push_back(K_JP);
    end
    limit = (abort_at >= 0) ? abort_at : steps.size();
    for (int i = 0; i < limit; i++) push(steps[i], op, $sformatf("ir%h_step%0d", ir, i));
    repeat (limit) @(posedge clk);
    #1;
    if (abort_at >= 0) begin
      do_reset();
    end else begin
      start = 1'b0;
      if (op inside {4'hA, 4'hB, 4'hC, 4'hD, 4'hE}) begin
        ill_m  = 1'b1;
        park_m = 2;
      end else begin
        cnt_m = cnt_m + 1'b1;
        if (op == 4'hF) park_m = 2;
      end
    end
  endtask

  // Monitor: one expected control word per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      act_o = {pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src, ir_write,
               acc_write, acc_src, alu_op, mem_we, halted, illegal, instr_count};
      vectors++;
      if (act_o !== cur_e.v) begin
        miscompares++;
        $display("FAIL %s: got %h required %h", cur_e.tag, act_o, cur_e.v);
      end
    end
  end

  initial begin
    logic [15:0] r;
    reset = 1'b1; start = 1'b0; ir_in = 16'h0000; acc_zero = 1'b0; acc_neg = 1'b0;
    vectors = 0; miscompares = 0; cnt_m = '0; ill_m = 1'b0; park_m = 1;
    @(posedge clk);
    #1 do_reset();
    park(2, 1'b1);
    run_instr(16'h1005, 1'b0, 1'b0, -1);
    run_instr(16'h2010, 1'b0, 1'b0, -1);
    run_instr(16'h8020, 1'b1, 1'b0, -1);
    run_instr(16'h8020, 1'b0, 1'b1, -1);
    run_instr(16'h9033, 1'b0, 1'b1, -1);
    run_instr(16'h9033, 1'b1, 1'b0, -1);
    run_instr(16'h7100, 1'b0, 1'b0, -1);
    run_instr(16'h3004, 1'b0, 1'b0, -1);
    run_instr(16'h4004, 1'b1, 1'b1, -1);
    run_instr(16'h5004, 1'b0, 1'b0, -1);
    run_instr(16'h6004, 1'b0, 1'b0, -1);
    run_instr(16'h0000, 1'b0, 1'b0, -1);
    run_instr(16'hB000, 1'b0, 1'b0, -1);
    park(3, 1'b1);
    run_instr(16'hF000, 1'b0, 1'b0, -1);
    park(1, 1'b1);
    run_instr(16'h2010, 1'b0, 1'b0, 5);
    park(2, 1'b1);
    run_instr(16'h3004, 1'b0, 1'b0, 5);
    park(1, 1'b1);
    for (int i = 0; i < 500; i++) begin
      if (park_m != 0) park($urandom_range(1, 3), 1'b1);
      r = 16'($urandom);
      run_instr(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit that sequences the accumulator datapath (PC, MAR, MBR, IR, ACC registers, ALU, synchronous-read main memory) through fetch, decode and execute.
Drives write strobes, mux selects, the ALU opcode and memory write-enable. Holds no datapath values; it reads only IR and ACC status flags.
Instantiated inside the top-level computer in place of the empty control stub.

Parameters:
ADDR_W, 14, memory address width; the IR operand field [11:0] is zero-extended to ADDR_W.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
start  in  1  level; sampled only in IDLE or HALT.
ir_in  in  16  IR contents; opcode = [15:12], operand address = [11:0].
acc_zero  in  1  ACC == 0.
acc_neg  in  1  ACC[15].
pc_write  out  1  PC load strobe.
pc_src  out  2  00 = PC+1, 01 = IR operand address, 10 = zero.
mar_write  out  1  MAR load strobe.
mar_src  out  1  0 = PC, 1 = IR operand address.
mbr_write  out  1  MBR load strobe.
mbr_src  out  1  0 = memory data_out, 1 = ACC.
ir_write  out  1  IR load strobe from memory data_out.
acc_write  out  1  ACC load strobe.
acc_src  out  1  0 = ALU result, 1 = MBR.
alu_op  out  4  ALU opcode: 0000 add, 0001 sub, 1000 and, 1001 or.
mem_we  out  1  main-memory write enable; memory is addressed by MAR and written from MBR.
halted  out  1  high in HALT.
illegal  out  1  sticky; set when an undefined opcode is decoded.
instr_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W.

Behaviour:
- Moore outputs, decoded from the registered state, so reset deasserts every strobe immediately. Reset values: all strobes 0, all selects 0, alu_op 0000, halted 0, illegal 0, instr_count 0.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 JUMP, 8 JZ (jump if acc_zero), 9 JN (jump if acc_neg), F HALT. Opcodes A-E are illegal.
- States and actions:
  - IDLE: on start, pc_write with pc_src=10, then go to F_ADDR.
  - F_ADDR: mar_write, mar_src=0.
  - F_MEM: one-cycle wait for the synchronous memory read; mem_we=0.
  - F_IR: ir_write, pc_write with pc_src=00.
  - DECODE: branch on ir_in[15:12].
  - E_ADDR: mar_write, mar_src=1. For STORE only, also mbr_write with mbr_src=1.
  - E_MEM: read wait.
  - E_MBR: mbr_write, mbr_src=0.
  - E_ACC: acc_write; acc_src=1 for LOAD, 0 with the mapped alu_op for ADD, SUB, AND and OR.
  - S_WR: mem_we=1.
  - JMP: pc_write, pc_src=01.
  - HALT: halted=1.
- Transitions out of DECODE:
  - LOAD, ADD, SUB, AND, OR: E_ADDR → E_MEM → E_MBR → E_ACC → F_ADDR (8 cycles total from F_ADDR).
  - STORE: E_ADDR → S_WR → F_ADDR (6 cycles).
  - JUMP, or JZ/JN with the condition true: JMP → F_ADDR (5 cycles).
  - NOP, or JZ/JN with the condition false: F_ADDR (4 cycles).
  - HALT: HALT.
  - Illegal opcode: set illegal, go to HALT.
- Branch conditions are sampled in DECODE only.
- instr_count increments by 1 on the final cycle of each instruction: E_ACC, S_WR, JMP, the DECODE cycle of NOP or an untaken branch, and the transition into HALT for the HALT opcode. An illegal opcode does not count. At all-ones it wraps to 0.
- HALT with start=1 clears illegal and behaves as IDLE+start: PC is zeroed and fetch restarts. instr_count is not cleared.
- start is ignored in every state except IDLE and HALT.
- At most one of pc_write, ir_write, acc_write and mem_we is asserted for a given destination per cycle. mem_we is never asserted in any state except S_WR.
- Reset asserted mid-instruction aborts it. No partial memory write occurs beyond the current S_WR edge.

Decomposition:
- Shared package holds: the opcode localparams (OP_NOP … OP_HALT), the ALU opcode constants (shared with the ALU), the pc_src encodings, and the state enumeration (4-bit).
- A single sub-module, cpu_control_decode, is natural: a combinational map from opcode, acc_zero and acc_neg to {next-state class, alu_op, acc_src, illegal}.

Test Plan:
- Reset then start=1 for one cycle → pc_write=1, pc_src=10 in IDLE. The F_ADDR, F_MEM, F_IR sequence follows with ir_write on the 3rd cycle after IDLE.
- ir_in=0x1005 (LOAD 5) → E_ACC reached 8 cycles after F_ADDR with acc_write=1, acc_src=1. instr_count goes 0→1.
- ir_in=0x2010 (STORE 0x10) → mem_we high for exactly 1 cycle, 6 cycles after F_ADDR. mbr_src=1 and mar_src=1 in E_ADDR.
- ir_in=0x8020 with acc_zero=1 → JMP with pc_src=01. With acc_zero=0 → back to F_ADDR after DECODE, 4-cycle instruction, no PC load.
- ir_in=0xB000 → illegal=1, halted=1, instr_count unchanged. start=1 → illegal clears and pc_src=10 load occurs.
- Assert reset during S_WR, and during E_MEM of an ADD → all outputs 0 immediately and state IDLE. instr_count=0 after reset; 0xFFFF+1 retire → 0x0000.
